// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the bit-serial adder.
//   state_e   : FSM state encoding (2'b11 is illegal and recovers to IDLE)
//   cnt_width : bit-counter width for a given operand width
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Counter must index bits 0..width-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder.
//   in_valid/in_ready   : operand handshake (a, b, cin)
//   out_valid/out_ready : result handshake (sum, cout)
// master = producer/consumer side, slave = adder side.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout
  );

endinterface

// File: rtl/serial_adder_full_add_gate.sv
// One-bit full adder built from gate primitives.
//   a, b, c : addend bits and carry-in
//   sum     : a ^ b ^ c
//   carry   : majority(a, b, c)
module full_add_gate (
  input  wire a,
  input  wire b,
  input  wire c,
  output wire sum,
  output wire carry
);

  wire ab;
  wire ac;
  wire bc;

  xor u_sum (sum, a, b, c);
  and u_ab  (ab, a, b);
  and u_ac  (ac, a, c);
  and u_bc  (bc, b, c);
  or  u_cy  (carry, ab, ac, bc);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: A + B + cin, LSB first, one bit per clock through a
// single full-adder cell. One operation every WIDTH+2 cycles.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : serial_adder_if.slave (operand and result handshakes)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e             state_q;
  state_e             state_d;
  logic [WIDTH-1:0]   a_sh_q;
  logic [WIDTH-1:0]   b_sh_q;
  logic [WIDTH-1:0]   sum_sh_q;
  logic               c_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               fa_s;
  logic               fa_co;
  logic               last_bit_c;
  logic               in_ready_c;
  logic               out_valid_c;

  assign last_bit_c = (cnt_q == CNT_W'(WIDTH - 1));

  full_add_gate u_fa (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .c     (c_q),
    .sum   (fa_s),
    .carry (fa_co)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the unused encoding falls back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid)  state_d = RUN;
      RUN:     if (last_bit_c)    state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      IDLE:    in_ready_c  = 1'b1;
      DONE:    out_valid_c = 1'b1;
      default: ;
    endcase
  end

  // Datapath: load on accept, shift one bit per RUN cycle, hold otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_sh_q <= bus.a;
            b_sh_q <= bus.b;
            c_q    <= bus.cin;
            cnt_q  <= '0;
          end
        end
        RUN: begin
          sum_sh_q <= {fa_s, sum_sh_q[WIDTH-1:1]};
          a_sh_q   <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q   <= {1'b0, b_sh_q[WIDTH-1:1]};
          c_q      <= fa_co;
          if (!last_bit_c) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  // After the last RUN edge, c_q holds the carry out of bit WIDTH-1
  assign bus.sum       = sum_sh_q;
  assign bus.cout      = c_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8 and WIDTH=4 instances).
module tb_serial_adder;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(4)) if4 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: true unsigned sum, including the carry into bit 8
  function automatic logic [8:0] ref_add8(input logic [7:0] a, input logic [7:0] b,
                                          input logic ci);
    return 9'(int'(a) + int'(b) + int'(ci));
  endfunction

  // Accept one WIDTH=8 operation and wait for out_valid (no result handshake).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci,
                        output int lat, output logic [8:0] res, output bit busy_ok);
    int w;
    w = 0;
    busy_ok = 1'b1;
    while (!if8.in_ready && w < 40) begin
      @(posedge clk); #1; w++;
    end
    if8.a = a; if8.b = b; if8.cin = ci; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after acceptance; they must not matter
    if8.in_valid = 1'b0; if8.a = '1; if8.b = '1; if8.cin = ~ci;
    lat = 0;
    while (!if8.out_valid && lat < 40) begin
      if (if8.in_ready) busy_ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
    if (if8.in_ready) busy_ok = 1'b0;
    res = {if8.cout, if8.sum};
  endtask

  task automatic finish_op();
    if8.out_ready = 1'b1;
    @(posedge clk); #1;
    if8.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total_cnt++; if (if8.in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", if8.in_ready); else pass_cnt++;
    total_cnt++; if (if8.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", if8.out_valid); else pass_cnt++;
    total_cnt++; if (if8.sum !== 8'h00) $display("FAIL reset_sum got=%h exp=00", if8.sum); else pass_cnt++;
    total_cnt++; if (if8.cout !== 1'b0) $display("FAIL reset_cout got=%b exp=0", if8.cout); else pass_cnt++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    int lat; logic [8:0] res; bit busy_ok;
    run_op(8'h00, 8'h00, 1'b0, lat, res, busy_ok);
    total_cnt++; if (lat !== 8) $display("FAIL zero_latency got=%0d exp=8", lat); else pass_cnt++;
    total_cnt++; if (res !== 9'h000) $display("FAIL zero_result got=%h exp=000", res); else pass_cnt++;
    total_cnt++; if (busy_ok !== 1'b1) $display("FAIL zero_in_ready_busy got=in_ready_high exp=low"); else pass_cnt++;
    finish_op();
    total_cnt++; if (if8.in_ready !== 1'b1) $display("FAIL zero_back_idle got=%b exp=1", if8.in_ready); else pass_cnt++;
  endtask

  task automatic test_carry_chain();
    int lat; logic [8:0] res; bit busy_ok;
    run_op(8'hFF, 8'h01, 1'b0, lat, res, busy_ok);
    total_cnt++; if (res !== ref_add8(8'hFF, 8'h01, 1'b0)) $display("FAIL ff_plus_1 got=%h exp=%h", res, ref_add8(8'hFF, 8'h01, 1'b0)); else pass_cnt++;
    finish_op();
    run_op(8'h5A, 8'hA5, 1'b1, lat, res, busy_ok);
    total_cnt++; if (res !== 9'h100) $display("FAIL full_chain got=%h exp=100", res); else pass_cnt++;
    finish_op();
  endtask

  task automatic test_backpressure();
    int lat; logic [8:0] res; bit busy_ok;
    run_op(8'h3C, 8'h0F, 1'b0, lat, res, busy_ok);
    total_cnt++; if (res !== 9'h04B) $display("FAIL bp_result got=%h exp=04b", res); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      // Second operand pulse while DONE must be ignored
      if (i == 1) begin if8.a = 8'h11; if8.b = 8'h00; if8.cin = 1'b0; if8.in_valid = 1'b1; end
      else if8.in_valid = 1'b0;
      @(posedge clk); #1;
      total_cnt++; if ({if8.cout, if8.sum} !== 9'h04B) $display("FAIL bp_hold cyc=%0d got=%h exp=04b", i, {if8.cout, if8.sum}); else pass_cnt++;
      total_cnt++; if (if8.out_valid !== 1'b1 || if8.in_ready !== 1'b0) $display("FAIL bp_flags cyc=%0d got=v%b r%b exp=v1 r0", i, if8.out_valid, if8.in_ready); else pass_cnt++;
    end
    if8.in_valid = 1'b0;
    finish_op();
    total_cnt++; if (if8.in_ready !== 1'b1 || if8.out_valid !== 1'b0) $display("FAIL bp_release got=r%b v%b exp=r1 v0", if8.in_ready, if8.out_valid); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (if8.in_ready !== 1'b1) $display("FAIL bp_pulse_ignored got=%b exp=1", if8.in_ready); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int lat; logic [8:0] res; bit busy_ok;
    if8.a = 8'hFF; if8.b = 8'h00; if8.cin = 1'b0; if8.in_valid = 1'b1;
    @(posedge clk); #1;
    if8.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total_cnt++; if (if8.out_valid !== 1'b0) $display("FAIL arst_out_valid got=%b exp=0", if8.out_valid); else pass_cnt++;
    total_cnt++; if (if8.in_ready !== 1'b1) $display("FAIL arst_in_ready got=%b exp=1", if8.in_ready); else pass_cnt++;
    total_cnt++; if (if8.sum !== 8'h00 || if8.cout !== 1'b0) $display("FAIL arst_result got=%b_%h exp=0_00", if8.cout, if8.sum); else pass_cnt++;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    run_op(8'h80, 8'h80, 1'b0, lat, res, busy_ok);
    total_cnt++; if (res !== 9'h100) $display("FAIL arst_after got=%h exp=100", res); else pass_cnt++;
    finish_op();
  endtask

  task automatic test_input_change();
    int lat; logic [8:0] res; bit busy_ok;
    run_op(8'h12, 8'h34, 1'b0, lat, res, busy_ok);
    total_cnt++; if (res !== 9'h046) $display("FAIL input_change got=%h exp=046", res); else pass_cnt++;
    finish_op();
  endtask

  task automatic test_random();
    int lat; logic [8:0] res; bit busy_ok;
    logic [7:0] ra, rb; logic rc; logic [8:0] exp_v;
    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
      exp_v = ref_add8(ra, rb, rc);
      run_op(ra, rb, rc, lat, res, busy_ok);
      total_cnt++; if (res !== exp_v || lat !== 8) $display("FAIL rand%0d a=%h b=%h c=%b got=%h lat=%0d exp=%h lat=8", i, ra, rb, rc, res, lat, exp_v); else pass_cnt++;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
      total_cnt++; if (if8.out_valid !== 1'b1 || {if8.cout, if8.sum} !== exp_v) $display("FAIL rand%0d_hold got=v%b %h exp=v1 %h", i, if8.out_valid, {if8.cout, if8.sum}, exp_v); else pass_cnt++;
      finish_op();
    end
  endtask

  task automatic test_sweep4();
    int idx, done, cyc, last_acc;
    logic [4:0] expq[$];
    logic [4:0] e;
    idx = 0; done = 0; cyc = 0; last_acc = -1;
    if4.in_valid = 1'b1; if4.out_ready = 1'b1;
    while (done < 512 && cyc < 4000) begin
      if (if4.out_valid) begin
        if (expq.size() > 0) e = expq.pop_front(); else e = 5'bx;
        total_cnt++; if ({if4.cout, if4.sum} !== e) $display("FAIL sweep4 res#%0d got=%h exp=%h", done, {if4.cout, if4.sum}, e); else pass_cnt++;
        done++;
      end
      if (if4.in_ready) begin
        if (idx < 512) begin
          if4.a = 4'(idx % 16); if4.b = 4'((idx / 16) % 16); if4.cin = 1'(idx / 256);
          expq.push_back(5'((idx % 16) + ((idx / 16) % 16) + (idx / 256)));
          if (last_acc >= 0) begin
            total_cnt++; if (cyc - last_acc !== 6) $display("FAIL sweep4 gap#%0d got=%0d exp=6", idx, cyc - last_acc); else pass_cnt++;
          end
          last_acc = cyc;
          idx++;
        end else begin
          if4.in_valid = 1'b0;
        end
      end
      @(posedge clk); #1; cyc++;
    end
    if4.in_valid = 1'b0;
    if4.out_ready = 1'b0;
    total_cnt++; if (done !== 512) $display("FAIL sweep4_count got=%0d exp=512", done); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    rst = 1'b1;
    if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0; if8.out_ready = 1'b0;
    if4.in_valid = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0; if4.out_ready = 1'b0;
    test_reset();
    test_zero();
    test_carry_chain();
    test_backpressure();
    test_async_reset();
    test_input_change();
    test_random();
    test_sweep4();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
